// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared opcode and FSM state encodings for the serial N-bit ALU.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Operation select, same control set as the 1-bit ALU slice
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  // Sequencer state encoding
  localparam int         ST_W    = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ADD and SLT both drive the carry chain onto the flags; AND/OR do not
  function automatic logic op_is_arith(input logic [1:0] op);
    return op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_digit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_digit
//  Brief    : Combinational DIGIT-bit ALU slice with ripple carry chain.
//             Reused every cycle by the serial ALU sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             ainv,
  input  logic             binv,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic [DIGIT-1:0] res_d,
  output logic [DIGIT-1:0] sum_d,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT-1:0] w_a;
  logic [DIGIT-1:0] w_b;
  logic [DIGIT:0]   w_c;

  // Inversion is applied per digit so the full-width inversion falls out
  assign w_a = a_d ^ {DIGIT{ainv}};
  assign w_b = b_d ^ {DIGIT{binv}};

  // Ripple the carry through the digit, producing the per-bit sum
  always_comb begin
    w_c    = '0;
    sum_d  = '0;
    w_c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum_d[i]  = w_a[i] ^ w_b[i] ^ w_c[i];
      w_c[i+1]  = (w_a[i] & w_b[i]) | (w_a[i] & w_c[i]) | (w_b[i] & w_c[i]);
    end
  end

  // Carry out of this digit and carry into its top bit (for overflow)
  assign cout     = w_c[DIGIT];
  assign c_msb_in = w_c[DIGIT-1];

  // Select the per-digit result by operation
  always_comb begin
    res_d = sum_d;
    unique case (op)
      OP_AND:  res_d = w_a & w_b;
      OP_OR:   res_d = w_a | w_b;
      default: res_d = sum_d;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_serial_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_serial_nbit
//  Brief    : Multi-cycle WIDTH-bit ALU processing DIGIT bits per cycle,
//             LSB digit first, with valid/ready handshakes and C/V/Z flags.
//  Revision : 1.0  initial release
// ============================================================================
module alu_serial_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainv,
  input  logic             binv,
  input  logic             carryin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int            N      = WIDTH / DIGIT;
  localparam int            CW     = $clog2(N) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  // Reject a digit size that does not tile the word
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("alu_serial_nbit: WIDTH must be a multiple of DIGIT");
  end

  logic [ST_W-1:0]    r_state;
  logic [ST_W-1:0]    w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_ainv;
  logic               r_binv;
  logic [1:0]         r_op;
  logic               r_carry;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry_out;
  logic               r_overflow;
  logic               r_zero;

  logic               w_accept;
  logic               w_last;
  logic [DIGIT-1:0]   w_res_d;
  logic [DIGIT-1:0]   w_sum_d;
  logic               w_cout;
  logic               w_cmsb;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic               w_ovf;
  logic               w_slt_bit;
  logic [WIDTH-1:0]   w_final;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == C_LAST);

  alu_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a_d      (r_a[DIGIT-1:0]),
    .b_d      (r_b[DIGIT-1:0]),
    .ainv     (r_ainv),
    .binv     (r_binv),
    .op       (r_op),
    .cin      (r_carry),
    .res_d    (w_res_d),
    .sum_d    (w_sum_d),
    .cout     (w_cout),
    .c_msb_in (w_cmsb)
  );

  // New digit enters at the MSB side; after N steps digit 0 sits at the LSB
  assign w_cat     = {w_res_d, r_acc};
  assign w_acc_nxt = w_cat[WIDTH+DIGIT-1:DIGIT];

  // On the last step the digit's top bit is the word MSB
  assign w_ovf     = w_cout ^ w_cmsb;
  assign w_slt_bit = w_sum_d[DIGIT-1] ^ w_ovf;
  assign w_final   = (r_op == OP_SLT) ? WIDTH'(w_slt_bit) : w_acc_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after N steps, DONE -> IDLE on out_ready
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, per-digit stepping and final result/flag registration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_ainv      <= 1'b0;
      r_binv      <= 1'b0;
      r_op        <= OP_AND;
      r_carry     <= 1'b0;
      r_acc       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_a     <= a;
      r_b     <= b;
      r_ainv  <= ainv;
      r_binv  <= binv;
      r_op    <= op;
      r_carry <= carryin;
      r_acc   <= '0;
    end else if (r_state == ST_RUN) begin
      r_cnt   <= r_cnt + CW'(1);
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_cout;
      r_acc   <= w_acc_nxt;
      if (w_last) begin
        r_result    <= w_final;
        r_carry_out <= op_is_arith(r_op) ? w_cout : 1'b0;
        r_overflow  <= op_is_arith(r_op) ? w_ovf  : 1'b0;
        r_zero      <= (w_final == '0);
      end
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_serial_nbit
//  Brief    : Directed-vector bench for alu_serial_nbit, DIGIT=1 and DIGIT=4
//             instances driven from the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_serial_nbit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b;
  logic       ainv, binv, carryin;
  logic [1:0] op;
  logic       out_ready;

  logic       in_ready1, out_valid1, carry_out1, overflow1, zero1;
  logic [7:0] result1;
  logic       in_ready4, out_valid4, carry_out4, overflow4, zero4;
  logic [7:0] result4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_serial_nbit #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .ainv(ainv), .binv(binv), .carryin(carryin), .op(op),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .carry_out(carry_out1), .overflow(overflow1), .zero(zero1)
  );

  alu_serial_nbit #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .ainv(ainv), .binv(binv), .carryin(carryin), .op(op),
    .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
    .carry_out(carry_out4), .overflow(overflow4), .zero(zero4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a bundle for one accept edge, then wait for both instances' results
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vai, input logic vbi, input logic vci, input logic [1:0] vop,
                        input logic [7:0] eres, input logic ec, input logic ev, input logic ez);
    int lat1, lat4;
    a = va; b = vb; ainv = vai; binv = vbi; carryin = vci; op = vop;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat1 = 0; lat4 = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (out_valid4 && lat4 == 0) lat4 = cyc - 1;
      if (out_valid1) begin lat1 = cyc - 1; break; end
      tick();
    end
    check({tag, " lat1"}, lat1, 8);
    check({tag, " lat4"}, lat4, 2);
    check({tag, " d1"}, {result1, carry_out1, overflow1, zero1}, {eres, ec, ev, ez});
    check({tag, " d4"}, {result4, carry_out4, overflow4, zero4}, {eres, ec, ev, ez});
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release in_ready", {in_ready1, out_valid1, in_ready4, out_valid4}, 4'b1010);
  endtask

  initial begin
    logic [10:0] held;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ainv = 1'b0; binv = 1'b0; carryin = 1'b0; op = 2'b00;
    tick(); tick();
    check("reset d1", {in_ready1, out_valid1, result1, carry_out1, overflow1, zero1}, {1'b1, 1'b0, 11'h0});
    check("reset d4", {in_ready4, out_valid4, result4, carry_out4, overflow4, zero4}, {1'b1, 1'b0, 11'h0});
    rst_n = 1'b1;
    tick();

    // Signed overflow into the MSB
    run_op("add7f", 8'h7F, 8'h01, 0, 0, 0, 2'b10, 8'h80, 0, 1, 0);
    release_out();
    // Subtract equal operands
    run_op("sub", 8'h05, 8'h05, 0, 1, 1, 2'b10, 8'h00, 1, 0, 1);
    release_out();
    // Unsigned wrap with carry out
    run_op("addff", 8'hFF, 8'h01, 0, 0, 0, 2'b10, 8'h00, 1, 0, 1);
    release_out();
    // SLT -128 < 1 and 1 < -128
    run_op("slt1", 8'h80, 8'h01, 0, 1, 1, 2'b11, 8'h01, 1, 1, 0);
    release_out();
    run_op("slt0", 8'h01, 8'h80, 0, 1, 1, 2'b11, 8'h00, 0, 1, 1);
    release_out();
    // Logic ops; carryin must be ignored
    run_op("and", 8'h0F, 8'hFF, 1, 0, 1, 2'b00, 8'hF0, 0, 0, 0);
    release_out();
    run_op("or", 8'h0F, 8'h30, 0, 0, 1, 2'b01, 8'h3F, 0, 0, 0);
    release_out();

    // Backpressure: held result, ignored bundle while in DONE
    run_op("bp", 8'h12, 8'h34, 0, 0, 0, 2'b10, 8'h46, 0, 0, 0);
    held = {result1, carry_out1, overflow1, zero1};
    a = 8'hAA; b = 8'h55; op = 2'b01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      in_valid = 1'b0;
      check("bp hold", {result1, carry_out1, overflow1, zero1}, {8'h46, 3'b000});
      check("bp hs", {in_ready1, out_valid1, in_ready4, out_valid4}, 4'b0101);
    end
    check("bp held word", held, {8'h46, 3'b000});
    release_out();
    run_op("post_bp", 8'h01, 8'h02, 0, 0, 0, 2'b10, 8'h03, 0, 0, 0);
    release_out();

    // Reset during the third RUN cycle aborts the operation
    a = 8'h7F; b = 8'h01; ainv = 0; binv = 0; carryin = 0; op = 2'b10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("rst run d1", {in_ready1, out_valid1, result1}, {1'b1, 1'b0, 8'h00});
    check("rst run d4", {in_ready4, out_valid4, result4}, {1'b1, 1'b0, 8'h00});
    rst_n = 1'b1;
    tick();
    run_op("after_rst", 8'h7F, 8'h01, 0, 0, 0, 2'b10, 8'h80, 0, 1, 0);
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
